// File: rtl/cpu_serializer.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on valid/ready and
// shifts it out MSB-first with a per-bit strobe for a CPU serial-load register.
// Ports: clk_i, rst_ni (async, active-low), valid_i, data_i, pause_i
//        -> ready_o, shift_o, bit_o, done_o, parity_o (CPU_SER_PARITY_EN only).
// Optional feature: define CPU_SER_PARITY_EN for the even-parity output.
module cpu_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pause_i,
  output logic             ready_o,
  output logic             shift_o,
  output logic             bit_o,
`ifdef CPU_SER_PARITY_EN
  output logic             done_o,
  output logic             parity_o
`else
  output logic             done_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
`ifdef CPU_SER_PARITY_EN
  logic             parity_q;
`endif

  assign ready_o = (state == IDLE);
  assign shift_o = (state == SHIFT) && !pause_i;
  assign bit_o   = (state == SHIFT) && shreg[WIDTH-1];
  assign done_o  = (state == DONE);
`ifdef CPU_SER_PARITY_EN
  assign parity_o = (state == DONE) && parity_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef CPU_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            shreg <= data_i;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
`ifdef CPU_SER_PARITY_EN
            parity_q <= ^data_i;
`endif
          end
        end
        SHIFT: begin
          // pause freezes everything, so bit_o stays on the pending bit
          if (!pause_i) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_serializer.sv
// Self-checking bench for cpu_serializer (WIDTH=8): scoreboard of expected
// bits/words fed at accept time and consumed by a negedge monitor.
module tb_cpu_serializer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       pause_i = 1'b0;
  logic       ready_o, shift_o, bit_o, done_o;
`ifdef CPU_SER_PARITY_EN
  logic       parity_o;
`endif

  int checks = 0;
  int failures = 0;

  logic       exp_bits[$];
  logic [7:0] exp_words[$];
  logic [7:0] rx = 8'h00;

  always #5 clk_i = ~clk_i;

  cpu_serializer #(.WIDTH(8)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .data_i  (data_i),
    .pause_i (pause_i),
    .ready_o (ready_o),
    .shift_o (shift_o),
    .bit_o   (bit_o),
`ifdef CPU_SER_PARITY_EN
    .done_o  (done_o),
    .parity_o(parity_o)
`else
    .done_o  (done_o)
`endif
  );

  // Paired serial-load receiver register.
  always @(posedge clk_i) if (shift_o) rx <= {rx[6:0], bit_o};

  // Scoreboard monitor: every strobed bit and every completed word.
  always @(negedge clk_i) begin
    if (shift_o) begin
      checks++;
      if (exp_bits.size() == 0) begin
        failures++;
        $display("FAIL sb_bit: unexpected shift, bit_o=%b", bit_o);
      end else begin
        logic eb;
        eb = exp_bits.pop_front();
        if (bit_o !== eb) begin
          failures++;
          $display("FAIL sb_bit: got %b expected %b", bit_o, eb);
        end
      end
    end
    if (done_o) begin
      checks++;
      if (exp_words.size() == 0) begin
        failures++;
        $display("FAIL sb_word: unexpected done_o, rx=%h", rx);
      end else begin
        logic [7:0] ew;
        ew = exp_words.pop_front();
        if (rx !== ew) begin
          failures++;
          $display("FAIL sb_word: rx got %h expected %h", rx, ew);
        end
      end
    end
`ifdef CPU_SER_PARITY_EN
    if (!done_o) begin
      checks++;
      if (parity_o !== 1'b0) begin
        failures++;
        $display("FAIL parity_idle: got %b expected 0", parity_o);
      end
    end
`endif
  end

  // Call just after a negedge with ready_o high; returns at cycle 1 (+1).
  task automatic accept(input logic [7:0] d);
    valid_i = 1'b1;
    data_i  = d;
    for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
    exp_words.push_back(d);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      checks++;
      if ({ready_o, shift_o, bit_o, done_o} !== 4'b1000) begin
        failures++;
        $display("FAIL reset_idle: cyc %0d outs=%b expected 1000", k,
                 {ready_o, shift_o, bit_o, done_o});
      end
    end
  endtask

  task automatic test_no_pause();
    logic [7:0] d;
    d = 8'hA5;
    accept(d);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      checks++;
      if (k <= 8) begin
        if (shift_o !== 1'b1 || bit_o !== d[8-k]) begin
          failures++;
          $display("FAIL a5_bit: cyc %0d shift=%b bit=%b expected 1/%b",
                   k, shift_o, bit_o, d[8-k]);
        end
      end else if (k == 9) begin
        if (done_o !== 1'b1 || rx !== d) begin
          failures++;
          $display("FAIL a5_done: done=%b rx=%h expected 1/%h",
                   done_o, rx, d);
        end
      end else if (ready_o !== 1'b1 || done_o !== 1'b0) begin
        failures++;
        $display("FAIL a5_ready: ready=%b done=%b expected 1/0",
                 ready_o, done_o);
      end
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
  endtask

  task automatic test_pause();
    accept(8'h3C);
    for (int k = 1; k <= 13; k++) begin
      pause_i = (k >= 3 && k <= 5);
      @(negedge clk_i);
      checks++;
      if (k >= 3 && k <= 5) begin
        if (shift_o !== 1'b0 || bit_o !== 1'b1) begin
          failures++;
          $display("FAIL pause_hold: cyc %0d shift=%b bit=%b expected 0/1",
                   k, shift_o, bit_o);
        end
      end else if (done_o !== (k == 12)) begin
        failures++;
        $display("FAIL pause_done: cyc %0d done=%b expected %b",
                 k, done_o, (k == 12));
      end
      @(posedge clk_i);
      #1;
    end
    pause_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    accept(8'h01);
    valid_i = 1'b1;
    data_i  = 8'hFF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== (k == 9 || k == 19) || ready_o !== (k == 10 || k == 20)) begin
        failures++;
        $display("FAIL b2b_timing: cyc %0d done=%b ready=%b", k, done_o, ready_o);
      end
      if (k == 10) begin
        for (int i = 7; i >= 0; i--) exp_bits.push_back(1'b1);
        exp_words.push_back(8'hFF);
      end
      @(posedge clk_i);
      #1;
      if (k == 10) valid_i = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    accept(8'hF0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({ready_o, shift_o, bit_o, done_o} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_mid: outs=%b expected 1000",
               {ready_o, shift_o, bit_o, done_o});
    end
    exp_bits.delete();
    exp_words.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0 || ready_o !== 1'b1) begin
        failures++;
        $display("FAIL rst_nodone: cyc %0d done=%b ready=%b", k, done_o, ready_o);
      end
    end
    accept(8'h0F);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== (k == 9)) begin
        failures++;
        $display("FAIL rst_after: cyc %0d done=%b expected %b", k, done_o, (k == 9));
      end
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
  endtask

`ifdef CPU_SER_PARITY_EN
  task automatic test_parity();
    logic [7:0] words[2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      accept(words[w]);
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk_i);
        if (k == 9) begin
          checks++;
          if (parity_o !== (w == 0)) begin
            failures++;
            $display("FAIL parity_done: word %h got %b expected %b",
                     words[w], parity_o, (w == 0));
          end
        end
        @(posedge clk_i);
        #1;
      end
      @(negedge clk_i);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_no_pause();
    test_pause();
    test_back_to_back();
    test_reset_mid();
`ifdef CPU_SER_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_bits.size() != 0 || exp_words.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: bits left %0d words left %0d expected 0/0",
               exp_bits.size(), exp_words.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
